// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and byte-lane mask helper for the LSU.
// LSU_MISALIGNED_SPLIT_EN adds the second-word access state ST_ACC1.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
`ifdef LSU_MISALIGNED_SPLIT_EN
    ST_ACC1 = 2'd2,
`endif
    ST_RESP = 2'd3
  } lsu_state_e;

  // Lane mask across two consecutive words: low nibble is the first word, high nibble the next.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data lane alignment and sign/zero extension.
// The 64-bit input holds {next word, first word} so split loads reuse the same shifter.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_rawData,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_dataExt
);

  logic [31:0] w_lane;

  assign w_lane = 32'(i_rawData >> {i_off, 3'b000});

  always_comb begin
    case (i_funct3)
      LB:      o_dataExt = {{24{w_lane[7]}}, w_lane[7:0]};
      LH:      o_dataExt = {{16{w_lane[15]}}, w_lane[15:0]};
      LBU:     o_dataExt = {24'h0, w_lane[7:0]};
      LHU:     o_dataExt = {16'h0, w_lane[15:0]};
      default: o_dataExt = w_lane;
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store sequencer for the single-ported data memory: lane enables, req/ack handshake, timeout.
// Define LSU_MISALIGNED_SPLIT_EN to turn misaligned accesses into two word accesses instead of faults.
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 255
)
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_isLoad,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_writeData,
  output logic              o_done,
  output logic              o_fault,
  output logic [31:0]       o_readDataExt,
  output logic              o_memReq,
  input  logic              i_memAck,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic              o_memWe,
  output logic [3:0]        o_memByteEn,
  output logic [31:0]       o_memWData,
  input  logic [31:0]       i_memRData
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam int NW = 2;
`else
  localparam int NW = 1;
`endif

  lsu_state_e        r_state;
  lsu_state_e        w_stateNext;
  logic              w_accept;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_reqFault;
  logic              w_inAcc;
  logic              w_timeout;
  logic              w_ackFinal;
  logic [1:0]        w_off;
  logic [63:0]       w_rawData;
  logic [31:0]       w_loadExt;
  logic [ADDR_W-1:0] r_addrWord;
  logic [1:0]        r_off;
  logic [2:0]        r_funct3;
  logic              r_isLoad;
  logic [4*NW-1:0]   r_byteEn;
  logic [32*NW-1:0]  r_wData;
  logic [31:0]       r_ackCnt;
  logic [31:0]       r_readDataExt;
  logic              r_fault;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              r_split;
  logic [31:0]       r_word0;
`endif

  assign w_off        = i_addr[1:0];
  assign w_accept     = i_valid && o_ready;
  assign w_illegal    = i_isLoad ? !(i_funct3 inside {LB, LH, LW, LBU, LHU})
                                 : !(i_funct3 inside {SB, SH, SW});
  assign w_misaligned = ((i_funct3[1:0] == 2'd1) && (w_off == 2'd3)) ||
                        ((i_funct3[1:0] == 2'd2) && (w_off != 2'd0));

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign w_reqFault = w_illegal;
  assign w_inAcc    = (r_state == ST_ACC0) || (r_state == ST_ACC1);
  assign w_ackFinal = i_memAck && ((r_state == ST_ACC1) || ((r_state == ST_ACC0) && !r_split));
  assign w_rawData  = (r_state == ST_ACC1) ? {i_memRData, r_word0} : {32'h0, i_memRData};
`else
  assign w_reqFault = w_illegal || w_misaligned;
  assign w_inAcc    = (r_state == ST_ACC0);
  assign w_ackFinal = i_memAck && (r_state == ST_ACC0);
  assign w_rawData  = {32'h0, i_memRData};
`endif

  // An ack in the last allowed cycle still wins over the timeout.
  assign w_timeout = w_inAcc && !i_memAck && (ACK_TIMEOUT != 0) &&
                     (r_ackCnt == 32'(ACK_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE, ST_RESP: w_stateNext = (w_accept && !w_reqFault) ? ST_ACC0 : ST_IDLE;
      ST_ACC0: begin
        if (i_memAck) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          w_stateNext = r_split ? ST_ACC1 : ST_RESP;
`else
          w_stateNext = ST_RESP;
`endif
        end else if (w_timeout) begin
          w_stateNext = ST_IDLE;
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ST_ACC1: begin
        if (i_memAck)       w_stateNext = ST_RESP;
        else if (w_timeout) w_stateNext = ST_IDLE;
      end
`endif
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_memReq    = 1'b0;
    o_memWe     = 1'b0;
    o_memByteEn = '0;
    o_memAddr   = '0;
    o_memWData  = '0;
    case (r_state)
      ST_IDLE: o_ready = 1'b1;
      ST_RESP: begin
        o_ready = 1'b1;
        o_done  = 1'b1;
      end
      ST_ACC0: begin
        o_memReq    = 1'b1;
        o_memWe     = !r_isLoad;
        o_memAddr   = r_addrWord;
        o_memByteEn = r_byteEn[3:0];
        o_memWData  = r_wData[31:0];
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ST_ACC1: begin
        o_memReq    = 1'b1;
        o_memWe     = !r_isLoad;
        o_memAddr   = r_addrWord + ADDR_W'(4);
        o_memByteEn = r_byteEn[7:4];
        o_memWData  = r_wData[63:32];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                      r_ackCnt <= '0;
    else if (w_stateNext != r_state) r_ackCnt <= '0;
    else if (w_inAcc)                r_ackCnt <= r_ackCnt + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_fault <= 1'b0;
    else       r_fault <= (w_accept && w_reqFault) || w_timeout;
  end

  // Request fields: outputs are gated by state, so these need no reset.
  always_ff @(posedge i_clk) begin
    if (w_accept && !w_reqFault) begin
      r_addrWord <= {i_addr[ADDR_W-1:2], 2'b00};
      r_off      <= w_off;
      r_funct3   <= i_funct3;
      r_isLoad   <= i_isLoad;
      r_byteEn   <= (4*NW)'(be_mask(i_funct3[1:0], w_off));
      r_wData    <= (32*NW)'({32'h0, i_writeData} << {w_off, 3'b000});
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_split    <= w_misaligned;
`endif
    end
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  always_ff @(posedge i_clk) begin
    if ((r_state == ST_ACC0) && i_memAck) r_word0 <= i_memRData;
  end
`endif

  lsu_load_align u_load_align (
    .i_rawData (w_rawData),
    .i_off     (r_off),
    .i_funct3  (r_funct3),
    .o_dataExt (w_loadExt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst)           r_readDataExt <= '0;
    else if (w_ackFinal) r_readDataExt <= w_loadExt;
  end

  assign o_readDataExt = r_readDataExt;
  assign o_fault       = r_fault;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Bench for lsu_access_ctrl: directed cases plus random requests against a byte-level reference model.
module tb_lsu_access_ctrl;

  localparam int TO = 4;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_isLoad;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_writeData;
  logic        o_done;
  logic        o_fault;
  logic [31:0] o_readDataExt;
  logic        o_memReq;
  logic        i_memAck;
  logic [31:0] o_memAddr;
  logic        o_memWe;
  logic [3:0]  o_memByteEn;
  logic [31:0] o_memWData;
  logic [31:0] i_memRData;

  int n_assert = 0;
  int n_fail   = 0;

  lsu_access_ctrl #(.ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_isLoad      (i_isLoad),
    .i_funct3      (i_funct3),
    .i_addr        (i_addr),
    .i_writeData   (i_writeData),
    .o_done        (o_done),
    .o_fault       (o_fault),
    .o_readDataExt (o_readDataExt),
    .o_memReq      (o_memReq),
    .i_memAck      (i_memAck),
    .o_memAddr     (o_memAddr),
    .o_memWe       (o_memWe),
    .o_memByteEn   (o_memByteEn),
    .o_memWData    (o_memWData),
    .i_memRData    (i_memRData)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // One request from idle; the model views memory as bytes and picks lanes by address.
  task automatic do_req(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int dly0, input int dly1,
                        input logic [31:0] rd0, input logic [31:0] rd1,
                        output logic [31:0] got);
    int          n, nacc, dly, w;
    bit          flt, mis, acked;
    logic [31:0] base, b, v, m;
    logic [31:0] rdw [2];
    logic [3:0]  be [2];
    logic [31:0] wexp [2];
    logic [1:0]  lane;
    got  = '0;
    n    = 1 << f3[1:0];
    flt  = ld ? (f3 == 3'd3 || f3 >= 3'd6) : (f3 > 3'd2);
    mis  = (int'(addr[1:0]) + n) > 4;
    if (mis && !SPLIT) flt = 1'b1;
    nacc = mis ? 2 : 1;
    base = addr & ~32'h3;
    rdw[0] = rd0; rdw[1] = rd1;

    chk("ready_idle", 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_isLoad = ld; i_funct3 = f3; i_addr = addr; i_writeData = wd;
    step();
    i_valid = 1'b0;
    if (flt) begin
      chk("fault_pulse", 32'(o_fault), 32'd1);
      chk("fault_noreq", 32'(o_memReq), 32'd0);
      step();
      chk("fault_clear", 32'(o_fault), 32'd0);
      chk("fault_noreq2", 32'(o_memReq), 32'd0);
      return;
    end
    chk("no_fault", 32'(o_fault), 32'd0);

    be[0] = '0; be[1] = '0; wexp[0] = '0; wexp[1] = '0; v = '0;
    for (int i = 0; i < n; i++) begin
      b    = addr + 32'(i);
      w    = ((b & ~32'h3) == base) ? 0 : 1;
      lane = b[1:0];
      be[w][lane]          = 1'b1;
      wexp[w][8*lane +: 8] = wd[8*i +: 8];
      v[8*i +: 8]          = rdw[w][8*lane +: 8];
    end
    if (f3 == 3'b000 && v[7])  v[31:8]  = '1;
    if (f3 == 3'b001 && v[15]) v[31:16] = '1;

    for (int k = 0; k < nacc; k++) begin
      dly   = (k == 0) ? dly0 : dly1;
      acked = 1'b0;
      for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{be[k][j]}};
      for (int c = 0; c < TO; c++) begin
        chk("mem_req", 32'(o_memReq), 32'd1);
        chk("mem_addr", o_memAddr, base + 32'(4 * k));
        chk("mem_be", 32'(o_memByteEn), 32'(be[k]));
        chk("mem_we", 32'(o_memWe), 32'(!ld));
        if (!ld) chk("mem_wdata", o_memWData & m, wexp[k]);
        chk("done_low", 32'(o_done), 32'd0);
        chk("ready_low", 32'(o_ready), 32'd0);
        i_valid  = 1'($urandom_range(0, 1));
        i_funct3 = 3'($urandom);
        if (c == dly) begin
          i_memAck   = 1'b1;
          i_memRData = rdw[k];
          acked      = 1'b1;
        end
        step();
        i_memAck   = 1'b0;
        i_valid    = 1'b0;
        i_memRData = $urandom;
        if (acked) break;
      end
      if (!acked) begin
        chk("to_req_drop", 32'(o_memReq), 32'd0);
        chk("to_fault", 32'(o_fault), 32'd1);
        chk("to_ready", 32'(o_ready), 32'd1);
        chk("to_no_done", 32'(o_done), 32'd0);
        step();
        chk("to_fault_clear", 32'(o_fault), 32'd0);
        return;
      end
    end

    chk("done_pulse", 32'(o_done), 32'd1);
    chk("ready_with_done", 32'(o_ready), 32'd1);
    chk("resp_no_fault", 32'(o_fault), 32'd0);
    chk("resp_no_req", 32'(o_memReq), 32'd0);
    if (ld) begin
      got = o_readDataExt;
      chk("load_data", got, v);
    end
    step();
    chk("done_single", 32'(o_done), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    i_rst = 1'b1; i_valid = 1'b0; i_isLoad = 1'b0; i_funct3 = '0; i_addr = '0;
    i_writeData = '0; i_memAck = 1'b0; i_memRData = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_req", 32'(o_memReq), 32'd0);
    chk("rst_we", 32'(o_memWe), 32'd0);
    chk("rst_be", 32'(o_memByteEn), 32'd0);
    chk("rst_addr", o_memAddr, 32'd0);
    chk("rst_wdata", o_memWData, 32'd0);
    chk("rst_rdata", o_readDataExt, 32'd0);
    i_rst = 1'b0;

    do_req(1'b1, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0, got);
    chk("lw_0x100", got, 32'hDEADBEEF);
    do_req(1'b1, 3'b000, 32'h103, 32'h0, 1, 0, 32'h80FFFF12, 32'h0, got);
    chk("lb_0x103", got, 32'hFFFFFF80);
    do_req(1'b1, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FFFF12, 32'h0, got);
    chk("lbu_0x103", got, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h202, 32'h0000ABCD, 3, 0, 32'h0, 32'h0, got);
    do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 1, 32'h56789ABC, 32'hEEEE1234, got);
`ifdef LSU_MISALIGNED_SPLIT_EN
    chk("lw_split_wrap", got, 32'h12345678);
`endif
    do_req(1'b1, 3'b010, 32'h40, 32'h0, 99, 0, 32'h0, 32'h0, got);
    do_req(1'b1, 3'b011, 32'h80, 32'h0, 0, 0, 32'h0, 32'h0, got);
    do_req(1'b0, 3'b100, 32'h84, 32'h1, 0, 0, 32'h0, 32'h0, got);

    // Reset while the first access is outstanding.
    i_valid = 1'b1; i_isLoad = 1'b1; i_funct3 = 3'b010; i_addr = 32'h300;
    step();
    i_valid = 1'b0;
    chk("mid_rst_req_before", 32'(o_memReq), 32'd1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mid_rst_req", 32'(o_memReq), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    chk("mid_rst_rdata", o_readDataExt, 32'd0);
    i_memAck = 1'b1;
    step();
    i_memAck = 1'b0;
    chk("mid_rst_no_done", 32'(o_done), 32'd0);
    chk("mid_rst_no_req", 32'(o_memReq), 32'd0);

    for (int t = 0; t < 150; t++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom, $urandom, got);
      i_memAck = 1'b1;
      step();
      i_memAck = 1'b0;
      chk("idle_ack_no_done", 32'(o_done), 32'd0);
      chk("idle_ack_no_req", 32'(o_memReq), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
